// File: rtl/writeback_lq_if.sv
// Writeback stage bus: in-order pipeline result, late-result channel (mul/div)
// and the merged register-file write port.
interface writeback_lq_if #(
  parameter int REGNO_WIDTH = 5,
  parameter int REG_WIDTH   = 32
);
  logic [REGNO_WIDTH-1:0] i_rd_no;
  logic [REG_WIDTH-1:0]   i_rd_val;
  logic                   i_late_vld;
  logic [REGNO_WIDTH-1:0] i_late_rd_no;
  logic [REG_WIDTH-1:0]   i_late_rd_val;
  logic                   o_late_rdy;
  logic [REGNO_WIDTH-1:0] o_rd_no;
  logic [REG_WIDTH-1:0]   o_rd_val;

  modport master (
    output i_rd_no, i_rd_val, i_late_vld, i_late_rd_no, i_late_rd_val,
    input  o_late_rdy, o_rd_no, o_rd_val
  );

  modport slave (
    input  i_rd_no, i_rd_val, i_late_vld, i_late_rd_no, i_late_rd_val,
    output o_late_rdy, o_rd_no, o_rd_val
  );
endinterface

// File: rtl/writeback_lq.sv
// Writeback stage merging pipeline results with a late-result queue (LQ).
// Optional macro WB_LATE_BYPASS_EN: live late result skips an empty, idle LQ.
module writeback_lq #(
  parameter  int REGNO_WIDTH = 5,
  parameter  int REG_WIDTH   = 32,
  parameter  int LQ_DEPTH    = 4,
  localparam int PTR_W       = $clog2(LQ_DEPTH),
  localparam int CNT_W       = PTR_W + 1,
  localparam int NREG        = 2 ** REGNO_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_exec_stall,
  input  logic                i_mem_stall,
  input  logic                i_fetch_stall,
  writeback_lq_if.slave       bus,
  output logic [CNT_W-1:0]    o_lq_count,
  output logic [NREG-1:0]     o_pending
);

  logic [REGNO_WIDTH-1:0] rd_no_q, rd_no_d;
  logic [REG_WIDTH-1:0]   rd_val_q, rd_val_d;
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic [REGNO_WIDTH-1:0] lq_rd_no_q [LQ_DEPTH];
  logic [REGNO_WIDTH-1:0] lq_rd_no_d [LQ_DEPTH];
  logic [REG_WIDTH-1:0]   lq_val_q   [LQ_DEPTH];
  logic [REG_WIDTH-1:0]   lq_val_d   [LQ_DEPTH];
  logic [LQ_DEPTH-1:0]    lq_kill_q, lq_kill_d;

  logic core_stall, pipe_wr, lq_full, lq_empty;
  logic push_acc, push_store, pop, bypass;

  assign core_stall = i_exec_stall | i_mem_stall | i_fetch_stall;
  assign pipe_wr    = !core_stall && (bus.i_rd_no != '0);
  assign lq_full    = (count_q == CNT_W'(LQ_DEPTH));
  assign lq_empty   = (count_q == '0);
  assign push_acc   = bus.i_late_vld && !lq_full;
  assign pop        = !pipe_wr && !lq_empty;

`ifdef WB_LATE_BYPASS_EN
  assign bypass = push_acc && (bus.i_late_rd_no != '0) && lq_empty && !pipe_wr;
`else
  assign bypass = 1'b0;
`endif

  // Register 0 means "no write": accepted from the producer but never stored.
  assign push_store = push_acc && (bus.i_late_rd_no != '0) && !bypass;

  always_comb begin
    rd_no_d    = '0;
    rd_val_d   = rd_val_q;
    head_d     = head_q;
    tail_d     = tail_q;
    lq_rd_no_d = lq_rd_no_q;
    lq_val_d   = lq_val_q;
    lq_kill_d  = lq_kill_q;

    if (pipe_wr) begin
      rd_no_d  = bus.i_rd_no;
      rd_val_d = bus.i_rd_val;
    end else if (pop) begin
      if (!lq_kill_q[head_q]) begin
        rd_no_d  = lq_rd_no_q[head_q];
        rd_val_d = lq_val_q[head_q];
      end
      head_d = head_q + 1'b1;
    end else if (bypass) begin
      rd_no_d  = bus.i_late_rd_no;
      rd_val_d = bus.i_late_rd_val;
    end

    // A pipeline write is younger than any queued late result to the same register.
    if (pipe_wr) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        if (lq_rd_no_q[i] == bus.i_rd_no) lq_kill_d[i] = 1'b1;
      end
    end

    if (push_store) begin
      lq_rd_no_d[tail_q] = bus.i_late_rd_no;
      lq_val_d[tail_q]   = bus.i_late_rd_val;
      lq_kill_d[tail_q]  = pipe_wr && (bus.i_late_rd_no == bus.i_rd_no);
      tail_d             = tail_q + 1'b1;
    end

    count_d = count_q + CNT_W'(push_store) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_no_q   <= '0;
      rd_val_q  <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      lq_kill_q <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_rd_no_q[i] <= '0;
        lq_val_q[i]   <= '0;
      end
    end else begin
      rd_no_q    <= rd_no_d;
      rd_val_q   <= rd_val_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      lq_kill_q  <= lq_kill_d;
      lq_rd_no_q <= lq_rd_no_d;
      lq_val_q   <= lq_val_d;
    end
  end

  // Per-entry pending contribution: occupied (offset from head below count) and not killed.
  logic [NREG-1:0] ent_mask [LQ_DEPTH];
  genvar gi;
  generate
    for (gi = 0; gi < LQ_DEPTH; gi++) begin : g_ent
      logic [PTR_W-1:0] offs;
      logic             live;
      assign offs          = PTR_W'(gi) - head_q;
      assign live          = ({1'b0, offs} < count_q) && !lq_kill_q[gi];
      assign ent_mask[gi]  = live ? (NREG'(1) << lq_rd_no_q[gi]) : '0;
    end
  endgenerate

  always_comb begin
    o_pending = '0;
    for (int i = 0; i < LQ_DEPTH; i++) o_pending = o_pending | ent_mask[i];
    o_pending[0] = 1'b0;
  end

  assign o_lq_count     = count_q;
  assign bus.o_late_rdy = !lq_full;
  assign bus.o_rd_no    = rd_no_q;
  assign bus.o_rd_val   = rd_val_q;

endmodule

// File: tb/tb_writeback_lq.sv
// Directed self-checking bench for writeback_lq (default build; bypass
// expectations switch with WB_LATE_BYPASS_EN).
module tb_writeback_lq;
  logic clk = 1'b0;
  logic rst;
  logic exec_stall, mem_stall, fetch_stall;
  logic [2:0]  lq_count;
  logic [31:0] pending;
  int n_checks = 0;
  int n_fail   = 0;

  writeback_lq_if #(.REGNO_WIDTH(5), .REG_WIDTH(32)) wb ();

  writeback_lq #(.REGNO_WIDTH(5), .REG_WIDTH(32), .LQ_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_exec_stall  (exec_stall),
    .i_mem_stall   (mem_stall),
    .i_fetch_stall (fetch_stall),
    .bus           (wb),
    .o_lq_count    (lq_count),
    .o_pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic idle();
    exec_stall = 0; mem_stall = 0; fetch_stall = 0;
    wb.i_rd_no = '0; wb.i_rd_val = '0;
    wb.i_late_vld = 0; wb.i_late_rd_no = '0; wb.i_late_rd_val = '0;
  endtask

  task automatic pipe(input logic [4:0] r, input logic [31:0] v);
    wb.i_rd_no = r; wb.i_rd_val = v;
  endtask

  task automatic late(input logic vld, input logic [4:0] r, input logic [31:0] v);
    wb.i_late_vld = vld; wb.i_late_rd_no = r; wb.i_late_rd_val = v;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [4:0] r, input logic [31:0] v);
    check({tag, ".rd_no"}, 64'(wb.o_rd_no), 64'(r));
    check({tag, ".rd_val"}, 64'(wb.o_rd_val), 64'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    check_out("reset", 5'd0, 32'h0);
    check("reset.count", 64'(lq_count), 64'd0);
    check("reset.pending", 64'(pending), 64'd0);
    check("reset.rdy", 64'(wb.o_late_rdy), 64'd1);

    // Pipeline result with one-cycle latency, then ignored under stall
    pipe(5'd3, 32'hDEADBEEF);
    step();
    check_out("pipe", 5'd3, 32'hDEADBEEF);
    exec_stall = 1; pipe(5'd4, 32'h1234);
    step();
    check_out("pipe_stall", 5'd0, 32'hDEADBEEF);

    // Drain under memory stall
    idle(); mem_stall = 1;
    late(1, 5'd5, 32'h11);
    step();
    check_out("drain0", 5'd0, 32'hDEADBEEF);
    check("drain0.count", 64'(lq_count), 64'd1);
    check("drain0.pending", 64'(pending), 64'h20);
    late(1, 5'd6, 32'h22);
    step();
    check_out("drain1", 5'd5, 32'h11);
    check("drain1.count", 64'(lq_count), 64'd1);
    check("drain1.pending", 64'(pending), 64'h40);
    late(0, 5'd0, 32'h0);
    step();
    check_out("drain2", 5'd6, 32'h22);
    check("drain2.pending", 64'(pending), 64'h0);
    step();
    check_out("drain3", 5'd0, 32'h22);
    check("drain3.count", 64'(lq_count), 64'd0);

    // Pipeline priority fills the queue; pointers wrap
    idle();
    for (int k = 0; k < 4; k++) begin
      pipe(5'd1, 32'h100 + 32'(k));
      late(1, 5'(20 + k), 32'hA0 + 32'(k));
      step();
      check_out($sformatf("fill%0d", k), 5'd1, 32'h100 + 32'(k));
    end
    check("full.count", 64'(lq_count), 64'd4);
    check("full.rdy", 64'(wb.o_late_rdy), 64'd0);
    check("full.pending", 64'(pending), 64'h00F0_0000);
    pipe(5'd1, 32'h200);
    late(1, 5'd24, 32'hBB);
    step();
    check("held.count", 64'(lq_count), 64'd4);
    pipe(5'd0, 32'h0);
    step();
    check_out("pop0", 5'd20, 32'hA0);
    check("pop0.count", 64'(lq_count), 64'd3);
    late(0, 5'd0, 32'h0);
    for (int k = 1; k < 4; k++) begin
      step();
      check_out($sformatf("pop%0d", k), 5'(20 + k), 32'hA0 + 32'(k));
    end
    step();
    check_out("popidle", 5'd0, 32'hA3);
    check("popidle.count", 64'(lq_count), 64'd0);

    // Kill of a stored entry by a younger pipeline write
    idle();
    pipe(5'd1, 32'h99); late(1, 5'd7, 32'h1);
    step();
    check("kill.pending_pre", 64'(pending), 64'h80);
    pipe(5'd7, 32'h2); late(0, 5'd0, 32'h0);
    step();
    check_out("kill.pipe", 5'd7, 32'h2);
    check("kill.pending", 64'(pending), 64'h0);
    check("kill.count", 64'(lq_count), 64'd1);
    idle();
    step();
    check_out("kill.pop", 5'd0, 32'h2);
    check("kill.count_after", 64'(lq_count), 64'd0);

    // Same-cycle push to the register being written is stored killed
    pipe(5'd8, 32'h3); late(1, 5'd8, 32'h4);
    step();
    check_out("samekill", 5'd8, 32'h3);
    check("samekill.pending", 64'(pending), 64'h0);
    idle();
    step();
    check_out("samekill.pop", 5'd0, 32'h3);

    // r0 late result is accepted and dropped
    late(1, 5'd0, 32'h77);
    step();
    check("r0.count", 64'(lq_count), 64'd0);
    check_out("r0", 5'd0, 32'h3);

    // Late result on empty, idle queue
    late(1, 5'd9, 32'h55);
    step();
    idle();
`ifdef WB_LATE_BYPASS_EN
    check_out("bypass", 5'd9, 32'h55);
    check("bypass.count", 64'(lq_count), 64'd0);
`else
    check_out("late0", 5'd0, 32'h3);
    check("late0.count", 64'(lq_count), 64'd1);
    step();
    check_out("late1", 5'd9, 32'h55);
`endif

    // Reset mid-traffic with three queued entries
    idle();
    for (int k = 0; k < 3; k++) begin
      pipe(5'd1, 32'h300); late(1, 5'(10 + k), 32'hC0);
      step();
    end
    check("midrst.count_pre", 64'(lq_count), 64'd3);
    check("midrst.pending_pre", 64'(pending), 64'h1C00);
    rst = 1;
    step(); step();
    check_out("midrst", 5'd0, 32'h0);
    check("midrst.count", 64'(lq_count), 64'd0);
    check("midrst.pending", 64'(pending), 64'h0);
    check("midrst.rdy", 64'(wb.o_late_rdy), 64'd1);
    rst = 0; idle();
    step();
    check_out("postrst", 5'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
